bev_engine_gen: RTL



---
 rtl/bev_engine_gen.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bev_engine_gen.sv
// Beverage inventory engine: make/supply/check actions on DRAM box records via a single-outstanding bridge.
// Optional `BOX_CACHE_EN adds a one-entry write-through record cache that skips the DRAM read on a hit.
module bev_engine_gen #(
  parameter int N_ING = 4,
  parameter int ING_W = 12,
  parameter int SUP_W = 12,
  parameter int BOX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     act_valid,
  input  logic [1:0]               act,
  input  logic                     date_valid,
  input  logic [3:0]               date_mon,
  input  logic [4:0]               date_day,
  input  logic                     box_valid,
  input  logic [BOX_W-1:0]         box_no,
  input  logic                     need_valid,
  input  logic [N_ING*ING_W-1:0]   need,
  input  logic                     amt_valid,
  input  logic [SUP_W-1:0]         amt,
  output logic                     c_in_valid,
  output logic                     c_r_wb,
  output logic [BOX_W-1:0]         c_addr,
  output logic [N_ING*ING_W+8:0]   c_data_w,
  input  logic                     c_out_valid,
  input  logic [N_ING*ING_W+8:0]   c_data_r,
  output logic                     out_valid,
  output logic [1:0]               err_msg,
  output logic                     complete
);
  localparam int REC_W = N_ING*ING_W + 9;
  localparam int SUM_W = ((SUP_W > ING_W) ? SUP_W : ING_W) + 1;
  localparam int CNT_W = $clog2(N_ING + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, RD_REQ, RD_WAIT, CALC, WB_REQ, WB_WAIT, RESP} state_t;
  typedef enum logic [1:0] {ACT_MAKE = 2'd0, ACT_SUPPLY = 2'd1, ACT_CHECK = 2'd2} act_t;

  state_t state, state_nx;
  act_t   act_r;

  logic [3:0]             mon_r;
  logic [4:0]             day_r;
  logic [BOX_W-1:0]       box_r;
  logic [N_ING*ING_W-1:0] need_r;
  logic [SUP_W-1:0]       amt_r [N_ING];
  logic [CNT_W-1:0]       beat_cnt;
  logic                   have_date, have_box, have_need, have_rec;
  logic [REC_W-1:0]       rec_r, wb_rec;
  logic [1:0]             err_r;

  logic                   collecting, fields_ok, expired, short_ing, sat_ing;
  logic                   cache_hit;
  logic [REC_W-1:0]       cache_data;
  logic [ING_W-1:0]       rec_ing [N_ING];
  logic [SUM_W-1:0]       sum [N_ING];
  logic [REC_W-1:0]       calc_rec;
  logic [1:0]             calc_err;
  logic                   calc_wr;

  assign collecting = (state == COLLECT) || (state == RD_REQ) || (state == RD_WAIT);
  assign fields_ok  = have_date && have_box &&
                      ((act_r == ACT_MAKE)   ? have_need :
                       (act_r == ACT_SUPPLY) ? (beat_cnt == CNT_W'(N_ING)) : 1'b1);
  assign expired    = (mon_r > rec_r[8:5]) || ((mon_r == rec_r[8:5]) && (day_r > rec_r[4:0]));

  assign c_in_valid = (state == RD_REQ) || (state == WB_REQ);
  assign c_addr     = box_r;
  assign c_data_w   = wb_rec;

`ifdef BOX_CACHE_EN
  logic             cache_valid;
  logic [BOX_W-1:0] cache_addr;
  logic [REC_W-1:0] cache_rec;

  assign cache_hit  = cache_valid && (cache_addr == box_r);
  assign cache_data = cache_rec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_rec   <= '0;
    end else if ((state == RD_WAIT) && c_out_valid) begin
      cache_valid <= 1'b1;
      cache_addr  <= box_r;
      cache_rec   <= c_data_r;
    end else if ((state == CALC) && calc_wr) begin
      cache_valid <= 1'b1;
      cache_addr  <= box_r;
      cache_rec   <= calc_rec;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < N_ING; i++) begin
      rec_ing[i] = rec_r[9 + i*ING_W +: ING_W];
      sum[i]     = SUM_W'(rec_ing[i]) + SUM_W'(amt_r[i]);
    end
  end

  always_comb begin
    calc_rec  = rec_r;
    calc_err  = 2'b00;
    calc_wr   = 1'b0;
    short_ing = 1'b0;
    sat_ing   = 1'b0;
    case (act_r)
      ACT_MAKE: begin
        for (int unsigned i = 0; i < N_ING; i++)
          if (rec_ing[i] < need_r[i*ING_W +: ING_W]) short_ing = 1'b1;
        if (expired) begin
          calc_err = 2'b01;
        end else if (short_ing) begin
          calc_err = 2'b10;
        end else begin
          calc_wr = 1'b1;
          for (int unsigned i = 0; i < N_ING; i++)
            calc_rec[9 + i*ING_W +: ING_W] = rec_ing[i] - need_r[i*ING_W +: ING_W];
        end
      end
      ACT_SUPPLY: begin
        calc_wr = 1'b1;
        for (int unsigned i = 0; i < N_ING; i++) begin
          if (sum[i][SUM_W-1:ING_W] != '0) begin
            sat_ing = 1'b1;
            calc_rec[9 + i*ING_W +: ING_W] = '1;
          end else begin
            calc_rec[9 + i*ING_W +: ING_W] = sum[i][ING_W-1:0];
          end
        end
        calc_rec[8:0] = {mon_r, day_r};
        calc_err      = sat_ing ? 2'b11 : 2'b00;
      end
      default: calc_err = expired ? 2'b01 : 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A record returned by the bridge goes back to COLLECT so late fields are still taken.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (act_valid && (act != 2'd3)) state_nx = COLLECT;
      COLLECT: begin
        if (have_rec && fields_ok)                    state_nx = CALC;
        else if (have_box && !have_rec && !cache_hit) state_nx = RD_REQ;
      end
      RD_REQ:  state_nx = RD_WAIT;
      RD_WAIT: if (c_out_valid) state_nx = COLLECT;
      CALC:    state_nx = calc_wr ? WB_REQ : RESP;
      WB_REQ:  state_nx = WB_WAIT;
      WB_WAIT: if (c_out_valid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_r     <= ACT_MAKE;
      mon_r     <= '0;
      day_r     <= '0;
      box_r     <= '0;
      need_r    <= '0;
      beat_cnt  <= '0;
      have_date <= 1'b0;
      have_box  <= 1'b0;
      have_need <= 1'b0;
      have_rec  <= 1'b0;
      rec_r     <= '0;
      wb_rec    <= '0;
      err_r     <= '0;
      c_r_wb    <= 1'b0;
      out_valid <= 1'b0;
      err_msg   <= '0;
      complete  <= 1'b0;
      for (int unsigned i = 0; i < N_ING; i++) amt_r[i] <= '0;
    end else begin
      if ((state == IDLE) && act_valid && (act != 2'd3)) act_r <= act_t'(act);
      if (collecting) begin
        if (date_valid) begin
          mon_r     <= date_mon;
          day_r     <= date_day;
          have_date <= 1'b1;
        end
        if (box_valid && !have_box) begin
          box_r    <= box_no;
          have_box <= 1'b1;
        end
        if (need_valid && (act_r == ACT_MAKE)) begin
          need_r    <= need;
          have_need <= 1'b1;
        end
        if (amt_valid && (act_r == ACT_SUPPLY) && (beat_cnt < CNT_W'(N_ING))) begin
          for (int unsigned i = 0; i < N_ING; i++)
            if (beat_cnt == CNT_W'(i)) amt_r[i] <= amt;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if ((state == COLLECT) && have_box && !have_rec && cache_hit) begin
        rec_r    <= cache_data;
        have_rec <= 1'b1;
      end
      if ((state == RD_WAIT) && c_out_valid) begin
        rec_r    <= c_data_r;
        have_rec <= 1'b1;
      end
      if (state_nx == RD_REQ && state != RD_REQ) c_r_wb <= 1'b1;
      if (state_nx == WB_REQ && state != WB_REQ) c_r_wb <= 1'b0;
      if (state == CALC) begin
        wb_rec <= calc_rec;
        err_r  <= calc_err;
      end
      if (state == RESP) begin
        beat_cnt  <= '0;
        have_date <= 1'b0;
        have_box  <= 1'b0;
        have_need <= 1'b0;
        have_rec  <= 1'b0;
      end
      out_valid <= 1'b0;
      err_msg   <= '0;
      complete  <= 1'b0;
      if ((state == CALC) && !calc_wr) begin
        out_valid <= 1'b1;
        err_msg   <= calc_err;
        complete  <= (calc_err == 2'b00);
      end else if ((state == WB_WAIT) && c_out_valid) begin
        out_valid <= 1'b1;
        err_msg   <= err_r;
        complete  <= (err_r == 2'b00);
      end
    end
  end
endmodule
